// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The master side issues read requests; the slave side returns words.
interface fetch_stage_if;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_data,
        input  imem_valid
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_data,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Single-slot instruction fetch stage with branch redirect and HLT detection.
// Optional build macro FETCH_ALIGN_CHECK_EN: odd branch targets raise align_err and halt.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [15:0]         branch_target,
    fetch_stage_if.master       imem,
    output logic [15:0]         instr,
    output logic                instr_valid,
    output logic [15:0]         pc_plus2,
    output logic                halted,
    output logic                align_err
);

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] instr_n;
    logic [15:0] pc_plus2_n;
    logic        instr_valid_n;
    logic [15:0] pc_inc;
    logic [15:0] redirect_pc;
    logic        slot_free;
    logic        consume;
    logic        xfer;

    assign pc_inc      = pc + 16'd2;
    assign redirect_pc = branch_target & 16'hFFFE;
    assign slot_free   = !instr_valid || !stall;
    assign consume     = instr_valid && !stall;

    // No request is visible while reset is asserted; the first one follows its release.
    assign imem.imem_rd_en = !rst && (state == FETCH) && slot_free && !branch_taken;
    assign imem.imem_addr  = pc & 16'hFFFE;
    assign xfer            = imem.imem_rd_en && imem.imem_valid;
    assign halted          = (state == HALTED);

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q, align_err_n;
    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        pc_plus2_n    = pc_plus2;
        instr_valid_n = instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
        align_err_n   = align_err_q;
`endif
        case (state)
            FETCH: begin
                if (branch_taken) begin
                    // Redirect wins over stall and over any response arriving this cycle.
                    instr_valid_n = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (branch_target[0]) begin
                        state_n     = HALTED;
                        align_err_n = 1'b1;
                    end else begin
                        pc_n = redirect_pc;
                    end
`else
                    pc_n = redirect_pc;
`endif
                end else if (xfer) begin
                    instr_n       = imem.imem_data;
                    instr_valid_n = 1'b1;
                    pc_plus2_n    = pc_inc;
                    pc_n          = pc_inc;
                    if (imem.imem_data[15:12] == OP_HLT) begin
                        state_n = HALTED;
                    end
                end else if (consume) begin
                    instr_valid_n = 1'b0;
                end
            end
            HALTED: begin
                if (consume) begin
                    instr_valid_n = 1'b0;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC & 16'hFFFE;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            pc_plus2    <= 16'h0000;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            pc_plus2    <= pc_plus2_n;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_n;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  downstream not consuming; hold instr/instr_valid.
- branch_taken  in  1  one-cycle redirect pulse from branch resolution.
- branch_target  in  16  redirect PC, valid with branch_taken.
- imem_rd_en  out  1  instruction memory read request.
- imem_addr  out  16  read address, always equals pc.
- imem_data  in  16  instruction word, valid with imem_valid.
- imem_valid  in  1  memory response; a transfer occurs only when imem_rd_en && imem_valid.
- instr  out  16  fetched instruction to decode; opcode is instr[15:12].
- instr_valid  out  1  instr holds an unconsumed instruction.
- pc_plus2  out  16  address of instr + 2, for PCS writeback and branch base.
- halted  out  1  HLT fetched; fetch stopped.
- align_err  out  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-003 States: FETCH and HALTED; no other states.
REQ-004 consume = instr_valid && !stall; slot_free = !instr_valid || !stall.
REQ-005 imem_rd_en = (state==FETCH) && slot_free && !branch_taken; combinational, no registered delay.
REQ-006 Transfer (imem_rd_en && imem_valid): instr <= imem_data, instr_valid <= 1, pc_plus2 <= pc+2, pc <= pc+2; zero-wait response supported, one instruction per cycle maximum.
REQ-007 No transfer and consume: instr_valid <= 0; instr and pc_plus2 keep their last values.
REQ-008 stall with instr_valid=1: instr, instr_valid and pc_plus2 frozen; imem_rd_en low; pc unchanged.
REQ-009 branch_taken in FETCH: pc <= {branch_target[15:1],1'b0}, instr_valid <= 0 (flush), imem_data discarded that cycle; takes priority over stall and over any concurrent response.
REQ-010 Transferred word with imem_data[15:12]==4'b1111 (HLT): state <= HALTED next cycle, halted <= 1, HLT presented on instr normally; pc still advances per REQ-006.
REQ-011 HALTED: imem_rd_en=0, pc frozen, branch_taken ignored, HLT drained per REQ-007; exit only by rst.
REQ-012 PC arithmetic 16-bit modulo: 16'hFFFE + 2 = 16'h0000, no error.
REQ-013 imem_addr bit 0 always 0.

Reset
REQ-014 rst sampled high at a clock edge: pc=RESET_PC, state=FETCH, instr=16'h0000, instr_valid=0, pc_plus2=16'h0000, halted=0, align_err=0.
REQ-015 rst overrides all inputs, including a transfer, branch or HLT in the same cycle; first request issues in the cycle after rst deasserts.

Configuration
REQ-016 Macro FETCH_ALIGN_CHECK_EN defined: branch_taken with branch_target[0]=1 sets align_err=1 (sticky until rst), enters HALTED, sets halted=1 and flushes instr_valid.
REQ-017 FETCH_ALIGN_CHECK_EN undefined: target bit 0 silently cleared per REQ-009; align_err tied to 0.

Verification
REQ-018 Reset, imem_valid always 1, stall=0 -> imem_addr 0000, 0002, 0004 on consecutive cycles; instr_valid high from the second cycle after reset release.
REQ-019 imem_valid held low 3 cycles -> imem_addr held at 0x0000, instr_valid 0, single transfer on the 4th cycle.
REQ-020 stall high 2 cycles with instr=0x1234 valid -> instr, pc_plus2 and instr_valid unchanged; imem_rd_en 0 in both cycles.
REQ-021 branch_taken with target 0x0040, concurrent stall and imem_valid -> next cycle instr_valid=0, imem_addr=0x0040.
REQ-022 imem_data=0xF000 at address 0x0010 -> halted=1, pc_plus2=0x0012, no further imem_rd_en; a later branch_taken has no effect.
REQ-023 FETCH_ALIGN_CHECK_EN defined, target 0x0041 -> align_err=1, halted=1. Undefined -> imem_addr=0x0040, align_err=0.
